// File: rtl/stack_sequencer.sv
// Command sequencer in front of a 16-bit LIFO: expands PUSH/POP/DUP/SWAP into
// single-word stack accesses and returns one response pulse per command.
module stack_sequencer #(
    parameter  int WIDTH   = 16,
    parameter  int DEPTH   = 16,
    localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [WIDTH-1:0]   req_data,
    output logic               rsp_valid,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err,
    output logic [DEPTH_W-1:0] depth,
    output logic               desync,
    output logic               stk_enable,
    output logic               stk_operation,
    output logic [WIDTH-1:0]   stk_data_in,
    input  logic [WIDTH-1:0]   stk_data_out,
    input  logic               stk_full,
    input  logic               stk_empty
);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_DUP  = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_PUSHR  = 4'd1,
        S_POP1   = 4'd2,
        S_CAP1   = 4'd3,
        S_POP2   = 4'd4,
        S_CAP2   = 4'd5,
        S_PUSHA  = 4'd6,
        S_PUSHA2 = 4'd7,
        S_PUSHB  = 4'd8,
        S_RESP   = 4'd9
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_data;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [DEPTH_W-1:0]   r_depth;
    logic                 r_desync;
    logic                 r_rsp_valid;
    logic                 r_rsp_err;
    logic [WIDTH-1:0]     r_rsp_data;

    logic                 w_accept;
    logic                 w_pre_ok;
    logic                 w_push_state;
    logic                 w_pop_state;
    logic                 w_push_issue;
    logic                 w_pop_issue;
    logic                 w_fault;
    logic                 w_rsp_err_nxt;
    logic [WIDTH-1:0]     w_rsp_data_nxt;
    logic [WIDTH-1:0]     w_stk_data_in;

    assign w_accept     = (r_state == S_IDLE) && req_valid;
    assign w_push_state = (r_state == S_PUSHR) || (r_state == S_PUSHA) ||
                          (r_state == S_PUSHA2) || (r_state == S_PUSHB);
    assign w_pop_state  = (r_state == S_POP1) || (r_state == S_POP2);
    // An access the real stack would refuse means the shadow count is wrong.
    assign w_push_issue = w_push_state && !stk_full;
    assign w_pop_issue  = w_pop_state && !stk_empty;
    assign w_fault      = (w_push_state && stk_full) || (w_pop_state && stk_empty);

    // Precondition check against the shadow depth at acceptance
    always_comb begin
        w_pre_ok = 1'b0;
        case (req_op)
            OP_PUSH: w_pre_ok = (r_depth < DEPTH_W'(DEPTH));
            OP_POP:  w_pre_ok = (r_depth >= DEPTH_W'(1));
            OP_DUP:  w_pre_ok = (r_depth >= DEPTH_W'(1)) && (r_depth <= DEPTH_W'(DEPTH - 1));
            OP_SWAP: w_pre_ok = (r_depth >= DEPTH_W'(2));
            default: w_pre_ok = 1'b0;
        endcase
    end

    // Next-state and response-content decode
    always_comb begin
        w_state_nxt    = r_state;
        w_rsp_err_nxt  = 1'b0;
        w_rsp_data_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (!w_pre_ok) begin
                        w_state_nxt   = S_RESP;
                        w_rsp_err_nxt = 1'b1;
                    end else if (req_op == OP_PUSH) begin
                        w_state_nxt = S_PUSHR;
                    end else begin
                        w_state_nxt = S_POP1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PUSHR: begin
                w_state_nxt   = S_RESP;
                w_rsp_err_nxt = w_fault;
            end
            S_POP1: begin
                if (w_fault) begin
                    w_state_nxt   = S_RESP;
                    w_rsp_err_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_CAP1;
                end
            end
            S_CAP1: begin
                case (r_op)
                    OP_POP: begin
                        // A is not captured yet on this edge, so forward the word
                        w_state_nxt    = S_RESP;
                        w_rsp_data_nxt = stk_data_out;
                    end
                    OP_DUP:  w_state_nxt = S_PUSHA;
                    OP_SWAP: w_state_nxt = S_POP2;
                    default: begin
                        w_state_nxt   = S_RESP;
                        w_rsp_err_nxt = 1'b1;
                    end
                endcase
            end
            S_POP2: begin
                if (w_fault) begin
                    w_state_nxt   = S_RESP;
                    w_rsp_err_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_CAP2;
                end
            end
            S_CAP2: begin
                w_state_nxt = S_PUSHA;
            end
            S_PUSHA: begin
                if (w_fault) begin
                    w_state_nxt   = S_RESP;
                    w_rsp_err_nxt = 1'b1;
                end else if (r_op == OP_DUP) begin
                    w_state_nxt = S_PUSHA2;
                end else begin
                    w_state_nxt = S_PUSHB;
                end
            end
            S_PUSHA2: begin
                w_state_nxt = S_RESP;
                if (w_fault) begin
                    w_rsp_err_nxt = 1'b1;
                end else begin
                    w_rsp_data_nxt = r_a;
                end
            end
            S_PUSHB: begin
                w_state_nxt = S_RESP;
                if (w_fault) begin
                    w_rsp_err_nxt = 1'b1;
                end else begin
                    w_rsp_data_nxt = r_b;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Push operand select per push state
    always_comb begin
        w_stk_data_in = '0;
        case (r_state)
            S_PUSHR:  w_stk_data_in = r_data;
            S_PUSHA:  w_stk_data_in = r_a;
            S_PUSHA2: w_stk_data_in = r_a;
            S_PUSHB:  w_stk_data_in = r_b;
            default:  w_stk_data_in = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latches, captured stack words, shadow depth and sticky desync
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= 2'b00;
            r_data   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_depth  <= '0;
            r_desync <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op   <= req_op;
                r_data <= req_data;
            end
            if (r_state == S_CAP1) begin
                r_a <= stk_data_out;
            end
            if (r_state == S_CAP2) begin
                r_b <= stk_data_out;
            end
            if (w_push_issue) begin
                r_depth <= r_depth + DEPTH_W'(1);
            end else if (w_pop_issue) begin
                r_depth <= r_depth - DEPTH_W'(1);
            end
            if (w_fault) begin
                r_desync <= 1'b1;
            end
        end
    end

    // Response registers; they line up with the RESP cycle and are zero elsewhere
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= (w_state_nxt == S_RESP);
            r_rsp_err   <= (w_state_nxt == S_RESP) && w_rsp_err_nxt;
            r_rsp_data  <= (w_state_nxt == S_RESP) ? w_rsp_data_nxt : '0;
        end
    end

    assign req_ready     = (r_state == S_IDLE);
    assign rsp_valid     = r_rsp_valid;
    assign rsp_err       = r_rsp_err;
    assign rsp_data      = r_rsp_data;
    assign depth         = r_depth;
    assign desync        = r_desync;
    assign stk_enable    = w_push_issue || w_pop_issue;
    assign stk_operation = w_push_state;
    assign stk_data_in   = w_stk_data_in;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: behavioural LIFO on the stack side, queue-based
// reference model of the command semantics, directed cases plus random commands.
module tb_stack_sequencer;
    localparam int WIDTH   = 16;
    localparam int DEPTH   = 16;
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [WIDTH-1:0]   req_data;
    logic               rsp_valid;
    logic [WIDTH-1:0]   rsp_data;
    logic               rsp_err;
    logic [DEPTH_W-1:0] depth;
    logic               desync;
    logic               stk_enable;
    logic               stk_operation;
    logic [WIDTH-1:0]   stk_data_in;
    logic [WIDTH-1:0]   stk_data_out;
    logic               stk_full;
    logic               stk_empty;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    stack_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .depth(depth), .desync(desync),
        .stk_enable(stk_enable), .stk_operation(stk_operation), .stk_data_in(stk_data_in),
        .stk_data_out(stk_data_out), .stk_full(stk_full), .stk_empty(stk_empty)
    );

    // Behavioural LIFO standing in for the real stack
    logic [WIDTH-1:0] dev_mem [DEPTH];
    int               dev_cnt = 0;
    int               acc_cnt = 0;
    logic [WIDTH-1:0] last_push = '0;
    logic             force_empty = 1'b0;

    assign stk_full  = (dev_cnt == DEPTH);
    assign stk_empty = (dev_cnt == 0) || force_empty;

    always @(posedge clk) begin
        if (rst) begin
            dev_cnt      <= 0;
            stk_data_out <= '0;
        end else if (stk_enable) begin
            acc_cnt <= acc_cnt + 1;
            if (stk_operation) begin
                last_push <= stk_data_in;
                if (dev_cnt < DEPTH) begin
                    dev_mem[dev_cnt] <= stk_data_in;
                    dev_cnt          <= dev_cnt + 1;
                end
            end else if (dev_cnt > 0) begin
                stk_data_out <= dev_mem[dev_cnt-1];
                dev_cnt      <= dev_cnt - 1;
            end
        end
    end

    // Reference model: expected stack contents (back = top) and sticky desync
    logic [WIDTH-1:0] exp_q[$];
    bit               exp_desync = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_data  = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        exp_desync = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] d);
        int               sz;
        int               exp_lat;
        int               exp_acc;
        int               lat;
        int               acc0;
        bit               ok_pre;
        bit               seen;
        logic             exp_err;
        logic [WIDTH-1:0] exp_data;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        sz = exp_q.size();
        case (op)
            2'b00:   ok_pre = (sz < DEPTH);
            2'b01:   ok_pre = (sz >= 1);
            2'b10:   ok_pre = (sz >= 1) && (sz <= DEPTH - 1);
            default: ok_pre = (sz >= 2);
        endcase
        exp_err  = 1'b0;
        exp_data = '0;
        exp_lat  = 1;
        exp_acc  = 0;
        if (!ok_pre) begin
            exp_err = 1'b1;
        end else if (force_empty && op != 2'b00) begin
            exp_err    = 1'b1;
            exp_lat    = 2;
            exp_desync = 1'b1;
        end else begin
            case (op)
                2'b00: begin exp_lat = 2; exp_acc = 1; exp_q.push_back(d); end
                2'b01: begin exp_lat = 3; exp_acc = 1; exp_data = exp_q.pop_back(); end
                2'b10: begin exp_lat = 5; exp_acc = 3; exp_data = exp_q[$]; exp_q.push_back(exp_data); end
                default: begin
                    exp_lat = 7; exp_acc = 4;
                    a = exp_q.pop_back();
                    b = exp_q.pop_back();
                    exp_q.push_back(a);
                    exp_q.push_back(b);
                    exp_data = b;
                end
            endcase
        end

        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        check_eq("req_ready", 32'(req_ready), 32'(1));
        acc0      = acc_cnt;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom_range(0, 3));
        req_data  = WIDTH'($urandom);
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check_eq("rsp_seen", 32'(seen), 32'(1));
        check_eq("latency", lat, exp_lat);
        check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
        check_eq("rsp_data", 32'(rsp_data), 32'(exp_data));
        check_eq("depth", 32'(depth), exp_q.size());
        check_eq("desync", 32'(desync), 32'(exp_desync));
        check_eq("accesses", acc_cnt - acc0, exp_acc);
        if (op == 2'b00 && !exp_err) check_eq("push_word", 32'(last_push), 32'(d));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'(1));
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check_eq("rst_rsp_err", 32'(rsp_err), 32'(0));
        check_eq("rst_rsp_data", 32'(rsp_data), 32'(0));
        check_eq("rst_depth", 32'(depth), 32'(0));
        check_eq("rst_desync", 32'(desync), 32'(0));
        check_eq("rst_stk_en", 32'(stk_enable), 32'(0));
        check_eq("rst_stk_op", 32'(stk_operation), 32'(0));
        check_eq("rst_stk_din", 32'(stk_data_in), 32'(0));

        run_cmd(2'b00, 16'h1234);

        do_reset();
        run_cmd(2'b00, 16'h000A);
        run_cmd(2'b00, 16'h000B);
        run_cmd(2'b11, 16'h0000);
        run_cmd(2'b01, 16'h0000);
        run_cmd(2'b01, 16'h0000);

        run_cmd(2'b00, 16'h00FF);
        run_cmd(2'b10, 16'h0000);
        run_cmd(2'b01, 16'h0000);
        run_cmd(2'b01, 16'h0000);

        run_cmd(2'b01, 16'h0000);
        run_cmd(2'b00, 16'h0042);
        run_cmd(2'b11, 16'h0000);

        do_reset();
        for (int i = 0; i < DEPTH; i++) run_cmd(2'b00, WIDTH'(i));
        run_cmd(2'b00, 16'h0099);
        run_cmd(2'b10, 16'h0000);
        run_cmd(2'b01, 16'h0000);

        do_reset();
        run_cmd(2'b00, 16'h0001);
        run_cmd(2'b00, 16'h0002);
        run_cmd(2'b00, 16'h0003);
        force_empty = 1'b1;
        run_cmd(2'b01, 16'h0000);
        force_empty = 1'b0;
        run_cmd(2'b00, 16'h0004);
        run_cmd(2'b01, 16'h0000);
        run_cmd(2'b11, 16'h0000);

        // Reset while the DUP is in its first push-back state
        do_reset();
        run_cmd(2'b00, 16'h00FF);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_data  = '0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_eq("mid_rsp_valid", 32'(rsp_valid), 32'(0));
        end
        check_eq("mid_push_en", 32'({stk_enable, stk_operation}), 32'(3));
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("abort_rsp_valid", 32'(rsp_valid), 32'(0));
        check_eq("abort_depth", 32'(depth), 32'(0));
        check_eq("abort_ready", 32'(req_ready), 32'(1));
        rst = 1'b0;
        exp_q.delete();
        exp_desync = 1'b0;
        run_cmd(2'b01, 16'h0000);

        do_reset();
        for (int n = 0; n < 300; n++) begin
            run_cmd(2'($urandom_range(0, 3)), WIDTH'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Initiator-side controller for the 16-bit LIFO `stack`. It drives that block's enable/operation/data_in and consumes its data_out/full/empty.
- Accepts one stack-machine command at a time from the core: PUSH, POP, DUP or SWAP. It expands each command into a sequence of single-word stack accesses, then returns a one-cycle response with result data or an error.
- Keeps a shadow depth count so that precondition failures are rejected before any stack access.

Parameters:
- WIDTH, 16, data word width; equals stack data width.
- DEPTH, 16, stack capacity in words; equals the instantiated stack's depth.
- DEPTH_W, $clog2(DEPTH+1), local; width of depth counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset; same net that resets the stack.
- req_valid  in  1  command present.
- req_ready  out  1  high only in IDLE; command accepted when req_valid&req_ready at clock edge.
- req_op  in  2  00 PUSH, 01 POP, 10 DUP, 11 SWAP.
- req_data  in  WIDTH  push operand (PUSH only).
- rsp_valid  out  1  one-cycle response pulse, no backpressure.
- rsp_data  out  WIDTH  POP/DUP: popped word; SWAP: new top; PUSH/error: 0.
- rsp_err  out  1  valid with rsp_valid; command rejected or aborted.
- depth  out  DEPTH_W  shadow word count.
- desync  out  1  sticky; stack full/empty disagreed with shadow depth.
- stk_enable  out  1  to stack enable.
- stk_operation  out  1  to stack operation; 1 push, 0 pop.
- stk_data_in  out  WIDTH  to stack data_in.
- stk_data_out  in  WIDTH  from stack data_out; valid the cycle after a pop is sampled.
- stk_full  in  1  from stack.
- stk_empty  in  1  from stack.

Behaviour:
- Stack contract:
  - Stack samples enable/operation/data_in at the rising edge.
  - Popped word is on stk_data_out the following cycle.
  - full/empty reflect the post-update count.
- Reset, synchronous, on rst=1 at an edge:
  - state=IDLE; depth=0; desync=0; internal regs A=B=0.
  - rsp_valid=0, rsp_err=0, rsp_data=0, stk_enable=0, stk_operation=0, stk_data_in=0.
- Reset mid-command: abandon the command, emit no response, return to IDLE.
- Stack outputs are Moore outputs of state. stk_enable=0 in every state except PUSH*/POP*.
- Precondition check in IDLE at acceptance, using depth:
  - PUSH needs depth<DEPTH.
  - POP needs depth>=1.
  - DUP needs 1<=depth<=DEPTH-1.
  - SWAP needs depth>=2.
  - On failure: go to RESP with err=1 and make no stack access.
- State sequences:
  - PUSH: IDLE -> PUSHR (push req_data) -> RESP.
  - POP: IDLE -> POP1 -> CAP1 (A<=stk_data_out) -> RESP, rsp_data=A.
  - DUP: POP1 -> CAP1 -> PUSHA (push A) -> PUSHA2 (push A) -> RESP, rsp_data=A.
  - SWAP: POP1 -> CAP1 -> POP2 -> CAP2 (B<=stk_data_out) -> PUSHA (push A) -> PUSHB (push B) -> RESP, rsp_data=B.
- Latency from acceptance edge to the rsp_valid cycle: error 1, PUSH 2, POP 3, DUP 5, SWAP 7 cycles.
- RESP lasts exactly one cycle, then IDLE. A new command is accepted earliest the cycle after RESP.
- req_data/req_op are latched at acceptance; later input changes are ignored.
- depth: +1 for each push issued, -1 for each pop issued, updated at the issuing edge. Net change per command: PUSH +1, POP -1, DUP +1, SWAP 0.
- Consistency check:
  - In a push state with stk_full=1, or a pop state with stk_empty=1: suppress stk_enable and set desync=1 (sticky until rst).
  - Then go to RESP with err=1. depth is not altered for the suppressed access.
- rsp_data/rsp_err are held at 0 when rsp_valid=0.

Test Plan:
- Reset then PUSH 0x1234 -> rsp_valid 2 cycles after accept, err=0, depth=1; stack saw exactly one push of 0x1234.
- PUSH 0x000A, PUSH 0x000B, SWAP -> rsp_data=0x000A; then POP -> 0x000A, POP -> 0x000B; depth ends at 0, desync=0.
- PUSH 0x00FF, DUP -> rsp 5 cycles after accept with data 0x00FF, depth=2; two POPs both return 0x00FF.
- Empty stack: POP -> err=1 one cycle after accept, no stk_enable pulse. SWAP with depth=1 -> err=1, depth stays 1.
- Fill to DEPTH=16 with PUSH 0..15: 17th PUSH -> err=1; DUP at depth 16 -> err=1; POP returns 15.
- Force stk_empty=1 while depth=3, then POP -> err=1, desync=1 (remains after later good commands).
- Assert rst during the DUP PUSHA state -> no rsp_valid, depth=0, req_ready=1 next cycle.
